// File: rtl/rl_pkg.sv
// Shared Q-learning datapath types and constants: widths, selector FSM states and LFSR polynomial.
// Used by the action selector and by the delay and update stages.
package rl_pkg;
  localparam int Q_W     = 16;
  localparam int STATE_W = 6;
  localparam int ACT_W   = 4;
  localparam int ADDR_W  = STATE_W + ACT_W;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  // Tap mask for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } sel_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/action_selector_if.sv
// Request/result handshake plus Q-table read port of the action selector.
// master = requester and Q-table side, slave = the selector itself.
interface action_selector_if;
  import rl_pkg::*;

  logic                      start;
  logic [STATE_W-1:0]        state_in;
  logic [7:0]                epsilon;
  logic                      explore_en;
  logic                      q_ren;
  logic [ADDR_W-1:0]         q_addr;
  logic signed [Q_W-1:0]     q_rdata;
  logic                      busy;
  logic                      valid;
  logic [ACT_W-1:0]          action;
  logic signed [Q_W-1:0]     max_q;
  logic                      explored;

  modport master (
    output start, state_in, epsilon, explore_en, q_rdata,
    input  q_ren, q_addr, busy, valid, action, max_q, explored
  );

  modport slave (
    input  start, state_in, epsilon, explore_en, q_rdata,
    output q_ren, q_addr, busy, valid, action, max_q, explored
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loads SEED on reset and steps every cycle.
// Latency: value changes every clock; no backpressure (never stalls).
module lfsr16
  import rl_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= SEED;
    else        value <= lfsr_step(value);
  end
endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selection: scans all Q-values of a state, picks argmax or a random action.
// Latency NUM_ACTIONS+2 cycles start->valid; no backpressure, start is ignored while busy.
module action_selector
  import rl_pkg::*;
#(
  parameter int          NUM_ACTIONS = 4,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  action_selector_if.slave bus
);
  localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(NUM_ACTIONS - 1);

  sel_state_e            state_q, state_d;
  logic                  accept;
  logic [15:0]           lfsr_val;
  logic [15:0]           snap_q;
  logic [STATE_W-1:0]    st_q;
  logic [7:0]            eps_q;
  logic                  en_q;
  logic [ACT_W-1:0]      a_q;
  logic [ACT_W-1:0]      rd_idx_q;
  logic                  rd_vld_q;
  logic signed [Q_W-1:0] run_max_q;
  logic [ACT_W-1:0]      run_idx_q;
  logic                  q_ren_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [ACT_W-1:0]      act_q;
  logic signed [Q_W-1:0] max_q_q;
  logic                  explored_q;
  logic                  take;
  logic signed [Q_W-1:0] new_max;
  logic [ACT_W-1:0]      new_idx;
  logic                  explore;
  logic [ACT_W-1:0]      rand_act;
  logic                  snap_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH:   if (a_q == ACT_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // First read (index 0) seeds the maximum; strict > keeps the lowest index on ties.
  always_comb begin
    take    = rd_vld_q && ((rd_idx_q == '0) || (bus.q_rdata > run_max_q));
    new_max = take ? bus.q_rdata : run_max_q;
    new_idx = take ? rd_idx_q    : run_idx_q;
  end

  assign explore     = en_q && (snap_q[7:0] < eps_q);
  assign rand_act    = snap_q[15:12] & ACT_LAST;
  assign snap_unused = ^snap_q[11:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= '0;
      eps_q      <= '0;
      en_q       <= 1'b0;
      snap_q     <= '0;
      a_q        <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      q_ren_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      act_q      <= '0;
      max_q_q    <= '0;
      explored_q <= 1'b0;
    end else begin
      if (accept) begin
        st_q   <= bus.state_in;
        eps_q  <= bus.epsilon;
        en_q   <= bus.explore_en;
        snap_q <= lfsr_val;
        a_q    <= '0;
      end else if (state_q == FETCH && a_q != ACT_LAST) begin
        a_q <= a_q + 1'b1;
      end

      // Strobes are decoded from the next state so they line up with it as registered outputs
      q_ren_q <= (state_d == FETCH);
      busy_q  <= (state_d == FETCH) || (state_d == DRAIN);
      valid_q <= (state_d == DONE);

      rd_vld_q  <= q_ren_q;
      rd_idx_q  <= a_q;
      run_max_q <= new_max;
      run_idx_q <= new_idx;

      if (state_q == DRAIN) begin
        act_q      <= explore ? rand_act : new_idx;
        max_q_q    <= new_max;
        explored_q <= explore;
      end
    end
  end

  assign bus.q_ren    = q_ren_q;
  assign bus.q_addr   = {st_q, a_q};
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.action   = act_q;
  assign bus.max_q    = max_q_q;
  assign bus.explored = explored_q;
endmodule

// File: tb/tb_action_selector.sv
// Bench for action_selector (N=4, seed 16'hB003): vector table, random runs against a reference
// model, and hand-written sequences for exploration, busy-start and mid-scan reset.
module tb_action_selector;
  import rl_pkg::*;

  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'hB003;
  localparam int          LAT  = N + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  action_selector_if sel_if ();

  action_selector #(.NUM_ACTIONS(N), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sel_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Q-table: data presented exactly one cycle after q_ren
  logic signed [15:0] qmem [0:1023];
  always @(posedge clk) if (sel_if.q_ren) sel_if.q_rdata <= qmem[sel_if.q_addr];

  // Reference LFSR: x^16+x^14+x^13+x^11+1, stepped once per clock outside reset
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  logic        tr_ren  [0:20];
  logic [9:0]  tr_addr [0:20];
  logic        tr_busy [0:20];

  typedef struct {
    logic [5:0] st;
    int         q0, q1, q2, q3;
    logic [7:0] eps;
    logic       en;
    int         exp_act;
    int         exp_max;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic load(input logic [5:0] st, input int q0, input int q1, input int q2, input int q3);
    qmem[{st, 4'd0}] = 16'(q0);
    qmem[{st, 4'd1}] = 16'(q1);
    qmem[{st, 4'd2}] = 16'(q2);
    qmem[{st, 4'd3}] = 16'(q3);
  endtask

  task automatic load_random(input logic [5:0] st);
    for (int i = 0; i < N; i++) begin
      int r;
      if ($urandom_range(0, 1) == 1) r = int'($urandom_range(0, 65535)) - 32768;
      else                           r = int'($urandom_range(0, 4)) - 2;
      qmem[{st, 4'(i)}] = 16'(r);
    end
  endtask

  // Argmax with lowest-index tie break, then the epsilon-greedy decision on the snapshot.
  function automatic void model(input logic [5:0] st, input logic [7:0] eps, input logic en,
                                input logic [15:0] snap, output int act, output int mq,
                                output int expl);
    int best_i = 0;
    int best_v = 0;
    for (int i = 0; i < N; i++) begin
      int v = qmem[{st, 4'(i)}];
      if (i == 0 || v > best_v) begin
        best_i = i;
        best_v = v;
      end
    end
    expl = (en && (int'(snap) % 256) < int'(eps)) ? 1 : 0;
    act  = (expl == 1) ? (int'(snap) / 4096) % N : best_i;
    mq   = best_v;
  endfunction

  // Called at posedge+#1 with the DUT idle; returns at the first cycle a new start may be given.
  task automatic run_sel(input logic [5:0] st, input logic [7:0] eps, input logic en,
                         output logic [3:0] act, output logic signed [15:0] mq, output logic expl,
                         output int lat, output logic [15:0] snap);
    sel_if.state_in   = st;
    sel_if.epsilon    = eps;
    sel_if.explore_en = en;
    sel_if.start      = 1'b1;
    snap = m_lfsr;
    lat  = 0;
    do begin
      @(posedge clk); #1;
      sel_if.start = 1'b0;
      lat++;
      tr_ren[lat]  = sel_if.q_ren;
      tr_addr[lat] = sel_if.q_addr;
      tr_busy[lat] = sel_if.busy;
    end while (!sel_if.valid && lat < 20);
    act  = sel_if.action;
    mq   = sel_if.max_q;
    expl = sel_if.explored;
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string tag, input logic [5:0] st, input logic [7:0] eps,
                           input logic en, output int expl_out);
    logic [3:0] act;
    logic signed [15:0] mq;
    logic expl;
    int lat;
    logic [15:0] snap;
    int e_act, e_mq, e_expl;
    run_sel(st, eps, en, act, mq, expl, lat, snap);
    model(st, eps, en, snap, e_act, e_mq, e_expl);
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".action"}, act, e_act);
    chk({tag, ".max_q"}, mq, e_mq);
    chk({tag, ".explored"}, expl, e_expl);
    expl_out = int'(expl);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".q_ren"}, sel_if.q_ren, 0);
    chk({tag, ".q_addr"}, sel_if.q_addr, 0);
    chk({tag, ".busy"}, sel_if.busy, 0);
    chk({tag, ".valid"}, sel_if.valid, 0);
    chk({tag, ".action"}, sel_if.action, 0);
    chk({tag, ".max_q"}, sel_if.max_q, 0);
    chk({tag, ".explored"}, sel_if.explored, 0);
  endtask

  initial begin
    vec_t tbl [6];
    logic [3:0] act;
    logic signed [15:0] mq;
    logic expl;
    int lat, ex, cnt, nval, c1, c2, a1, m2;
    logic [15:0] snap;

    sel_if.start = 1'b0;
    sel_if.state_in = '0;
    sel_if.epsilon = '0;
    sel_if.explore_en = 1'b0;
    for (int i = 0; i < 1024; i++) qmem[i] = '0;
    load(6'd5, 100, -20, 300, 7);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // First edge after release samples start with the LFSR still at SEED = 16'hB003
    rst_n = 1'b1;
    run_sel(6'd5, 8'd255, 1'b1, act, mq, expl, lat, snap);
    chk("explore.latency", lat, 6);
    chk("explore.action", act, 3);
    chk("explore.max_q", mq, 300);
    chk("explore.explored", expl, 1);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("trace.q_ren[%0d]", c), tr_ren[c], 1);
      chk($sformatf("trace.q_addr[%0d]", c), tr_addr[c], 10'h050 + c - 1);
    end
    chk("trace.q_ren[5]", tr_ren[5], 0);
    for (int c = 1; c <= 5; c++) chk($sformatf("trace.busy[%0d]", c), tr_busy[c], 1);
    chk("trace.busy[6]", tr_busy[6], 0);

    tbl[0] = '{6'd5,  100, -20, 300, 7, 8'd0, 1'b0, 2, 300};
    tbl[1] = '{6'd9,  -5, -5, -9, -5, 8'd200, 1'b0, 0, -5};
    tbl[2] = '{6'd10, -32768, 32767, 32767, 0, 8'd0, 1'b1, 1, 32767};
    tbl[3] = '{6'd63, 0, 0, 0, 0, 8'd0, 1'b1, 0, 0};
    tbl[4] = '{6'd0,  -1, -2, -3, 1, 8'd255, 1'b0, 3, 1};
    tbl[5] = '{6'd12, -32768, -32768, -32768, -32768, 8'd0, 1'b0, 0, -32768};
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].st, tbl[i].q0, tbl[i].q1, tbl[i].q2, tbl[i].q3);
      run_sel(tbl[i].st, tbl[i].eps, tbl[i].en, act, mq, expl, lat, snap);
      chk($sformatf("vec%0d.latency", i), lat, LAT);
      chk($sformatf("vec%0d.action", i), act, tbl[i].exp_act);
      chk($sformatf("vec%0d.max_q", i), mq, tbl[i].exp_max);
      chk($sformatf("vec%0d.explored", i), expl, 0);
    end

    for (int i = 0; i < 100; i++) begin
      logic [5:0] st = 6'($urandom_range(16, 62));
      load_random(st);
      run_check($sformatf("rand%0d", i), st, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ex);
    end

    for (int i = 0; i < 200; i++) begin
      logic [5:0] st = 6'($urandom_range(16, 62));
      load_random(st);
      run_check($sformatf("eps0_%0d", i), st, 8'd0, 1'b1, ex);
    end

    cnt = 0;
    load_random(6'd40);
    for (int i = 0; i < 3000; i++) begin
      run_check("eps64", 6'd40, 8'd64, 1'b1, ex);
      cnt += ex;
    end
    n_tests++;
    if (cnt < 660 || cnt > 840) begin
      n_fail++;
      $display("FAIL eps64.fraction: got %0d of 3000 explored, expected 660..840", cnt);
    end

    // start pulses at cycles 2 and 4 are ignored; the one at cycle 7 is accepted
    load(6'd5, 100, -20, 300, 7);
    load(6'd9, -5, -5, -9, -5);
    nval = 0; c1 = -1; c2 = -1; a1 = -1; m2 = 0;
    sel_if.state_in = 6'd5;
    sel_if.explore_en = 1'b0;
    sel_if.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      sel_if.start    = (c == 2 || c == 4 || c == 7);
      sel_if.state_in = (c == 7) ? 6'd9 : 6'd10;
      if (sel_if.valid) begin
        nval++;
        if (nval == 1) begin c1 = c; a1 = int'(sel_if.action); end
        if (nval == 2) begin c2 = c; m2 = int'(sel_if.max_q); end
      end
    end
    sel_if.start = 1'b0;
    chk("busy_start.valid_count", nval, 2);
    chk("busy_start.first_cycle", c1, 6);
    chk("busy_start.first_action", a1, 2);
    chk("busy_start.second_cycle", c2, 13);
    chk("busy_start.second_max_q", m2, -5);

    sel_if.state_in = 6'd5;
    sel_if.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      sel_if.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midscan_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (sel_if.valid) cnt++;
    end
    chk("midscan_reset.stale_valid", cnt, 0);
    run_check("after_reset", 6'd5, 8'd255, 1'b1, ex);
    run_check("after_reset_greedy", 6'd5, 8'd0, 1'b0, ex);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
